boot_frame_loader: RTL
======================

// Module: boot_frame_loader
// PURPOSE
//  Framed UART boot loader sitting directly downstream of uart_receiver (consumes rx_dv/rx_byte).
//  Parses a sync/length/data/checksum frame, packs bytes into 32-bit little-endian words, and
//  drives an ICCM write port. Holds the core in reset while loading; flags done or error.
// PARAMETERS
//  AddrWidth      12       ICCM word-address width
//  MaxWords       4096     largest accepted frame length (words); must be <= 2**AddrWidth
//  TimeoutCycles  100000   idle cycles between bytes mid-frame before abort
//  SyncByte       8'hA5    frame start marker
// PORTS
//  clk_i       in   1          system clock
//  rst_ni      in   1          reset, synchronous, active-low
//  rx_dv_i     in   1          one-cycle strobe: rx_byte_i valid
//  rx_byte_i   in   8          received byte
//  we_o        out  1          ICCM write strobe, one cycle per word
//  addr_o      out  AddrWidth  ICCM word address
//  wdata_o     out  32         ICCM write data
//  hold_rst_o  out  1          1 = keep core in reset (load in progress or failed)
//  done_o      out  1          level: last frame loaded successfully
//  err_o       out  1          level: last frame aborted
// BEHAVIOUR
//  - Frame: SyncByte, LEN[7:0], LEN[15:8], LEN*4 data bytes (LSB first per word), [CHK].
//  - Reset (rst_ni=0 at posedge): state IDLE, all outputs 0, counters/accumulators cleared.
//    Reset mid-frame discards the frame; no further we_o.
//  - FSM: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR. Transitions only on rx_dv_i, except timeout.
//    IDLE/DONE/ERR: byte==SyncByte -> LEN_LO, hold_rst_o=1, done_o=0, err_o=0, word idx=0,
//      chk=0; other bytes ignored (no state change).
//    LEN_LO -> LEN_HI; LEN_HI -> DATA if 1<=LEN<=MaxWords, else ERR.
//    DATA: byte n (n=0..3) -> word[8n+7:8n]; on n=3 word complete.
//      Next cycle: we_o=1 for exactly 1 cycle, addr_o=word idx, wdata_o=word; idx++.
//      After word LEN-1: -> CHK (macro on) or DONE (macro off).
//    DONE: hold_rst_o=0, done_o=1. ERR: err_o=1, hold_rst_o stays 1 (partial image never runs).
//  - Latency: we_o registered, 1 cycle after the rx_dv_i of the 4th byte. Back-to-back rx_dv_i on
//    consecutive cycles is supported; a write pulse may coincide with the next byte's capture.
//  - Final-word write pulse always issues, even if DONE/ERR is entered the same cycle.
//  - addr_o/wdata_o hold their last value between pulses; idx never wraps (bounded by MaxWords).
//  - Timeout: in LEN_LO/LEN_HI/DATA/CHK a counter clears on every rx_dv_i and increments
//    otherwise; reaching TimeoutCycles -> ERR. An rx_dv_i in the timeout cycle itself is dropped.
//  - Checksum: chk = XOR of LEN_LO, LEN_HI and all data bytes (sync excluded).
// CONFIGURATION
//  BOOT_LDR_CHKSUM_EN defined: CHK byte expected after data.
//    CHK==chk -> DONE, else -> ERR (writes already issued stand; hold_rst_o stays 1).
//  Not defined: no CHK state, no checksum byte; DONE immediately after the last word's
//    rx_dv_i; XOR logic absent.
// TESTING
//  1. A5 02 00 44 33 22 11 EF BE AD DE 64 (macro on) -> we_o@addr0=32'h11223344,
//     @addr1=32'hDEADBEEF; done_o=1, hold_rst_o=0, err_o=0.
//  2. Same frame with CHK=65 -> both writes seen, err_o=1, done_o=0, hold_rst_o=1;
//     resending case 1 then yields done_o=1.
//  3. A5 00 00 -> err_o=1 after LEN_HI byte, no we_o. A5 01 20 with MaxWords=4096 (LEN=0x2001)
//     -> err_o=1, no we_o.
//  4. 00 FF 5A before a valid frame -> ignored, state IDLE, hold_rst_o=0, no we_o;
//     frame then loads normally.
//  5. TimeoutCycles=16: A5 01 00 44 33 then silence -> err_o=1 exactly 16 cycles after
//     last rx_dv_i, no we_o.
//  6. rst_ni low for 1 cycle after 2 data bytes -> all outputs 0 next cycle; bytes 01 02 then
//     ignored; fresh case-1 frame loads correctly.
//     Macro-off build: case 1 minus CHK byte -> done_o after 2nd write.

Source files
------------

// File: rtl/boot_frame_loader.sv
// Framed UART boot loader: sync/length/data[/checksum] frames packed into 32-bit ICCM writes.
// Define BOOT_LDR_CHKSUM_EN to require a trailing XOR checksum byte after the data.
module boot_frame_loader #(
  parameter int          AddrWidth     = 12,
  parameter int          MaxWords      = 4096,
  parameter int          TimeoutCycles = 100000,
  parameter logic [7:0]  SyncByte      = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_dv_i,
  input  logic [7:0]           rx_byte_i,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [31:0]          wdata_o,
  output logic                 hold_rst_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CHK    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;
  localparam int TW = $clog2(TimeoutCycles + 1);

  logic [2:0]           state;
  logic [7:0]           len_lo;
  logic [15:0]          len;
  logic [AddrWidth-1:0] idx;
  logic [1:0]           bcnt;
  logic [23:0]          acc;
  logic [TW-1:0]        tmo;
  logic [15:0]          len_full;
  logic                 len_ok, last_word, tmo_hit, idle_like;
`ifdef BOOT_LDR_CHKSUM_EN
  logic [7:0]           chk;
`endif

  assign len_full  = {rx_byte_i, len_lo};
  assign len_ok    = (len_full != 16'd0) && (32'(len_full) <= MaxWords);
  assign last_word = (32'(idx) + 32'd1) == 32'(len);
  assign tmo_hit   = tmo == TW'(TimeoutCycles - 1);
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      len_lo     <= '0;
      len        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      acc        <= '0;
      tmo        <= '0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      hold_rst_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
`ifdef BOOT_LDR_CHKSUM_EN
      chk        <= '0;
`endif
    end else begin
      we_o <= 1'b0;
      if (idle_like) begin
        if (rx_dv_i && rx_byte_i == SyncByte) begin
          state      <= LEN_LO;
          hold_rst_o <= 1'b1;
          done_o     <= 1'b0;
          err_o      <= 1'b0;
          idx        <= '0;
          bcnt       <= '0;
          tmo        <= '0;
`ifdef BOOT_LDR_CHKSUM_EN
          chk        <= '0;
`endif
        end
      end else if (tmo_hit) begin
        // Timeout wins over a byte arriving in the same cycle.
        state <= ERR;
        err_o <= 1'b1;
      end else if (!rx_dv_i) begin
        tmo <= tmo + 1'b1;
      end else begin
        tmo <= '0;
`ifdef BOOT_LDR_CHKSUM_EN
        if (state != CHK) chk <= chk ^ rx_byte_i;
`endif
        case (state)
          LEN_LO: begin
            len_lo <= rx_byte_i;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            len <= len_full;
            if (len_ok) state <= DATA;
            else begin
              state <= ERR;
              err_o <= 1'b1;
            end
          end
          DATA: begin
            bcnt <= bcnt + 1'b1;
            case (bcnt)
              2'd0:    acc[7:0]   <= rx_byte_i;
              2'd1:    acc[15:8]  <= rx_byte_i;
              2'd2:    acc[23:16] <= rx_byte_i;
              default: begin
                we_o    <= 1'b1;
                addr_o  <= idx;
                wdata_o <= {rx_byte_i, acc};
                if (last_word) begin
`ifdef BOOT_LDR_CHKSUM_EN
                  state <= CHK;
`else
                  state      <= DONE;
                  done_o     <= 1'b1;
                  hold_rst_o <= 1'b0;
`endif
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            endcase
          end
`ifdef BOOT_LDR_CHKSUM_EN
          CHK: begin
            if (rx_byte_i == chk) begin
              state      <= DONE;
              done_o     <= 1'b1;
              hold_rst_o <= 1'b0;
            end else begin
              state <= ERR;
              err_o <= 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
